// File: rtl/inst_sequencer.sv
// Instruction sequencer: drives the core's 34-bit instruction bus through one
// weight-stationary tile (weight load, kernel load, activation load, execute,
// psum write-back) and signals completion with a single-cycle done pulse.
// Optional feature macro INST_SEQ_READBACK_EN adds a psum read-back (RB) phase
// after write-back that streams the psums to the SFP with acc=1.
module inst_sequencer #(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned len    = 36,
    parameter int unsigned W_BASE = 1024,
    parameter int unsigned A_BASE = 0,
    parameter int unsigned P_BASE = 0,
    parameter int unsigned DRAIN  = row + col
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  l0_ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    localparam logic [33:0] NOP = 34'h1800C0000;

`ifdef INST_SEQ_READBACK_EN
    typedef enum logic [3:0] {
        StIdle, StWRd, StWFl, StKLd, StKDr, StARd, StAFl, StEx, StEDr, StWb, StRb, StDone
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StWRd, StWFl, StKLd, StKDr, StARd, StAFl, StEx, StEDr, StWb, StDone
    } state_e;
`endif

    state_e      state, state_d;
    logic [15:0] k, k_d;
    logic [33:0] inst_d;
    logic        l0_full, ofifo_v;
    logic        rd_go, wr_go;
    logic [10:0] rd_addr, p_addr;
    logic        unused_status;

    assign l0_full       = l0_ofifo_valid[1];
    assign ofifo_v       = l0_ofifo_valid[4];
    assign unused_status = ^{l0_ofifo_valid[3:2], l0_ofifo_valid[0]};

    // Next state and counter base; k_d is the count seen by the state about to run.
    always_comb begin
        state_d = state;
        k_d     = k + 16'd1;
        case (state)
            StIdle: if (start) state_d = StWRd;
            StWRd: begin
                k_d = k;
                if (k == 16'(col)) state_d = StWFl;
            end
            StWFl: state_d = StKLd;
            StKLd: if (k == 16'(col - 1)) state_d = StKDr;
            StKDr: if (k == 16'(DRAIN - 1)) state_d = StARd;
            StARd: begin
                k_d = k;
                if (k == 16'(len)) state_d = StAFl;
            end
            StAFl: state_d = StEx;
            StEx:  if (k == 16'(len - 1)) state_d = StEDr;
            StEDr: if (k == 16'(DRAIN - 1)) state_d = StWb;
            StWb: begin
                k_d = k;
`ifdef INST_SEQ_READBACK_EN
                if (k == 16'(len)) state_d = StRb;
`else
                if (k == 16'(len)) state_d = StDone;
`endif
            end
`ifdef INST_SEQ_READBACK_EN
            StRb:  if (k == 16'(len - 1)) state_d = StDone;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Every state starts counting from zero on entry
        if (state_d != state) k_d = '0;
    end

    // Issue decisions and addresses for the instruction registered at this edge
    always_comb begin
        rd_go   = ((state_d == StWRd) || (state_d == StARd)) && !l0_full;
        wr_go   = (state_d == StWb) && ofifo_v;
        rd_addr = ((state_d == StWRd) ? 11'(W_BASE) : 11'(A_BASE)) + k_d[10:0];
        p_addr  = 11'(P_BASE) + k_d[10:0];
    end

    // Instruction word for the state about to run; fields default to NOP
    always_comb begin
        inst_d    = NOP;
        // l0_wr trails the xmem read by the SRAM's one-cycle read latency
        inst_d[2] = ~inst[19];
        case (state_d)
            StWRd, StARd: begin
                if (rd_go) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = rd_addr;
                end
            end
            StKLd: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            StEx: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            StWb: begin
                if (wr_go) begin
                    inst_d[6]     = 1'b1;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = p_addr;
                end
            end
`ifdef INST_SEQ_READBACK_EN
            StRb: begin
                inst_d[33]    = 1'b1;
                inst_d[32]    = 1'b0;
                inst_d[30:20] = p_addr;
            end
`endif
            default: ;
        endcase
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
            k     <= '0;
            inst  <= NOP;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            k     <= (rd_go || wr_go) ? k_d + 16'd1 : k_d;
            inst  <= inst_d;
            busy  <= (state_d != StIdle);
            done  <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: table of tile scenarios plus
// hand-written reset sequences.
module tb_inst_sequencer;

    localparam logic [33:0] NOP = 34'h1800C0000;
    localparam int COL    = 8;
    localparam int LEN    = 36;
    localparam int W_BASE = 1024;
    localparam int A_BASE = 0;
    localparam int P_BASE = 0;
`ifdef INST_SEQ_READBACK_EN
    localparam int RBX = 36;
`else
    localparam int RBX = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  l0_ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    inst_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .l0_ofifo_valid (l0_ofifo_valid),
        .inst           (inst),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Results of the last tile run
    int r_first, r_lat, r_xcnt, r_xbad, r_pcnt, r_pbad, r_load, r_exec;
    int r_l0wr, r_l0rd, r_done, r_wblen, r_busy_hi, r_busy_lo, r_acc, r_accbad;

    // mode: 0 clean, 1 l0 full stall in W_RD, 2 alternating ofifo valid, 3 start while busy
    task automatic run_tile(input int mode);
        int first_wr, last_wr, exp_addr;
        r_first = 0; r_lat = -1; r_xcnt = 0; r_xbad = 0; r_pcnt = 0; r_pbad = 0;
        r_load = 0; r_exec = 0; r_l0wr = 0; r_l0rd = 0; r_done = 0; r_wblen = 0;
        r_busy_hi = 0; r_busy_lo = 1; r_acc = 0; r_accbad = 0;
        first_wr = -1; last_wr = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 0) r_first = (inst != NOP) ? 1 : 0;
            if (!inst[19]) begin
                exp_addr = (r_xcnt < COL) ? W_BASE + r_xcnt : A_BASE + r_xcnt - COL;
                if (inst[17:7] != 11'(exp_addr) || !inst[18]) r_xbad++;
                r_xcnt++;
            end
            if (!inst[32] && !inst[31]) begin
                if (inst[30:20] != 11'(P_BASE + r_pcnt) || !inst[6]) r_pbad++;
                if (first_wr < 0) first_wr = n;
                last_wr = n;
                r_pcnt++;
            end else if (inst[6]) begin
                r_pbad++;
            end
            if (inst[33]) begin
                if (inst[32] || !inst[31] || inst[30:20] != 11'(P_BASE + r_acc)) r_accbad++;
                r_acc++;
            end
            if (inst[0]) r_load++;
            if (inst[1]) r_exec++;
            if (inst[2]) r_l0wr++;
            if (inst[3]) r_l0rd++;
            if (done) r_done++;
            if (r_lat >= 0 && n > r_lat) begin
                r_busy_lo = busy ? 1 : 0;
                break;
            end
            if (done && r_lat < 0) begin
                r_lat = n;
                r_busy_hi = busy ? 1 : 0;
            end
            l0_ofifo_valid[1] = (mode == 1 && n >= 3 && n <= 5);
            l0_ofifo_valid[4] = (mode == 2) ? (n < 121 || n % 2 == 1) : 1'b1;
            start = (mode == 3 && n == 50);
            @(posedge clk); #1;
        end
        if (first_wr >= 0) r_wblen = last_wr - first_wr + 1;
        l0_ofifo_valid = 5'b10000;
        start = 1'b0;
    endtask

    task automatic check_tile(input string nm, input int lat, input int wblen);
        check({nm, ".first_nonnop"}, r_first, 1);
        check({nm, ".latency"}, r_lat, lat);
        check({nm, ".xmem_reads"}, r_xcnt, COL + LEN);
        check({nm, ".xmem_addr_err"}, r_xbad, 0);
        check({nm, ".pmem_writes"}, r_pcnt, LEN);
        check({nm, ".pmem_addr_err"}, r_pbad, 0);
        check({nm, ".load_cycles"}, r_load, COL);
        check({nm, ".exec_cycles"}, r_exec, LEN);
        check({nm, ".l0_wr"}, r_l0wr, COL + LEN);
        check({nm, ".l0_rd"}, r_l0rd, COL + LEN);
        check({nm, ".done_pulses"}, r_done, 1);
        check({nm, ".wb_cycles"}, r_wblen, wblen);
        check({nm, ".busy_at_done"}, r_busy_hi, 1);
        check({nm, ".busy_after"}, r_busy_lo, 0);
        check({nm, ".acc_cycles"}, r_acc, RBX);
        check({nm, ".acc_err"}, r_accbad, 0);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    lat;
        int    wblen;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nop_bad;
        vecs[0] = '{name: "clean",      mode: 0, lat: 158 + RBX, wblen: 36};
        vecs[1] = '{name: "clean2",     mode: 0, lat: 158 + RBX, wblen: 36};
        vecs[2] = '{name: "l0_stall",   mode: 1, lat: 161 + RBX, wblen: 36};
        vecs[3] = '{name: "ofifo_alt",  mode: 2, lat: 193 + RBX, wblen: 71};
        vecs[4] = '{name: "busy_start", mode: 3, lat: 158 + RBX, wblen: 36};

        reset = 1'b1;
        start = 1'b0;
        l0_ofifo_valid = 5'b10000;
        #3 reset = 1'b0;
        #1;
        check("reset.inst_is_nop", (inst == NOP) ? 1 : 0, 1);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        nop_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (inst != NOP || busy || done) nop_bad++;
        end
        check("idle.nop_hold", nop_bad, 0);

        for (int v = 0; v < 5; v++) begin
            run_tile(vecs[v].mode);
            check_tile(vecs[v].name, vecs[v].lat, vecs[v].wblen);
        end

        // Reset in the middle of EX (k=10 is cycle 80 from the first read)
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("mid.in_exec", int'(inst[1]), 1);
        reset = 1'b0;
        #1;
        check("mid.reset_nop", (inst == NOP) ? 1 : 0, 1);
        check("mid.reset_busy", int'(busy), 0);
        check("mid.reset_done", int'(done), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("mid.idle_after", (inst == NOP && !busy) ? 1 : 0, 1);
        run_tile(0);
        check_tile("after_reset", 158 + RBX, 36);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Initiator for the core's 34-bit instruction bus.
- Replaces the testbench-driven instruction stream with an FSM that runs one complete weight-stationary tile:
  - xmem→L0 weight transfer, then kernel load
  - xmem→L0 activation transfer, then execute
  - OFIFO→psum SRAM write-back
- Sits beside core. Its inst output drives core.inst, and it consumes core's L0/OFIFO status bits.

Parameters:
- row, 8, PE array rows
- col, 8, PE array columns (number of weight words)
- len, 36, activation words per tile (also the number of psum words)
- W_BASE, 1024, xmem address of the first weight word (11 bit)
- A_BASE, 0, xmem address of the first activation word (11 bit)
- P_BASE, 0, pmem address of the first psum word (11 bit)
- DRAIN, 16, idle cycles after kernel load and after execute (row+col)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start request
- l0_ofifo_valid  in  5  core status: [4] ofifo valid, [1] l0 full, others unused
- inst  out  34  instruction word to core: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters 0; busy=0; done=0.
  - inst=NOP=34'h1800C0000 (CEN/WEN of both memories =1, every other bit 0).
- inst is fully registered. Fields not listed for a state take their NOP value. ififo_wr, ififo_rd and acc are always 0.
- Timing: the state is entered on edge t; its inst value is visible from t onward. Counter k restarts at 0 on every state entry.
- IDLE: inst=NOP. start=1 → W_RD. start is ignored in every other state.
- W_RD (col issue cycles):
  - Each cycle with l0 full=0: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+k, k++.
  - Cycle with l0 full=1: xmem idle, k held (stall).
  - l0_wr equals a 1-cycle-delayed copy of "read issued" (SRAM read latency 1).
  - After k reaches col → W_FL.
- W_FL (1 cycle): l0_wr for the last word only → K_LD.
- K_LD (col cycles): l0_rd=1, load=1 → K_DR.
- K_DR (DRAIN cycles): NOP → A_RD.
- A_RD / A_FL: same as W_RD / W_FL, using A_BASE and len words → EX.
- EX (len cycles): l0_rd=1, execute=1 → E_DR.
- E_DR (DRAIN cycles): NOP → WB.
- WB:
  - Each cycle with ofifo valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=P_BASE+k, k++.
  - Cycle with ofifo valid=0: NOP (stall).
  - After len writes → DONE.
- DONE (1 cycle): done=1, inst=NOP → IDLE. busy drops when IDLE is entered.
- Stall-free tile latency: (col+1)+col+DRAIN+(len+1)+len+DRAIN+len = 158 cycles, from the first non-NOP inst to the DONE cycle.
- Address arithmetic is 11 bit modulo 2048; wrap past 2047 is allowed and is not flagged.
- A stall never drops or duplicates an address; the delayed l0_wr still fires for a read issued in the cycle before the stall.
- Reset mid-operation: immediate return to IDLE with inst=NOP. No partial flush.

Optional Feature:
- Macro: INST_SEQ_READBACK_EN.
- Defined: WB → RB instead of WB → DONE.
  - RB (len cycles): CEN_pmem=0, WEN_pmem=1, acc=1, A_pmem=P_BASE+k. This streams the psums to the SFP.
  - RB → DONE. Stall-free latency becomes 194 cycles.
- Undefined: the RB state and its logic are absent; acc is tied to 0.

Test Plan:
- Reset asserted, then released: inst=34'h1800C0000, busy=0, done=0; inst holds NOP with start=0 for 20 cycles.
- start pulse, no stalls (l0 full=0, ofifo valid=1):
  - A_xmem 1024..1031, then 0..35.
  - load high for exactly 8 cycles; execute high for exactly 36 cycles.
  - A_pmem 0..35 with WEN_pmem=0; done pulses once, 158 cycles after the first non-NOP inst.
- l0 full held high for 3 cycles during W_RD at k=4: A_xmem holds at 1028 progression with no repeat or skip; l0_wr count =8; total latency 161.
- ofifo valid low on alternate cycles in WB: exactly 36 writes, A_pmem contiguous 0..35, WB lasts 71 cycles.
- Second start pulse while busy: ignored; exactly one done pulse. A start pulse after done begins an identical second tile.
- reset pulsed low during EX at k=10: inst=NOP and busy=0 asynchronously; the next start runs a full 158-cycle tile.
- With INST_SEQ_READBACK_EN defined: after WB, 36 cycles of acc=1, WEN_pmem=1, A_pmem 0..35; done at cycle 194.
